// File: rtl/version_pkg.sv
// Build identification constants stamped into every build-info frame.
// Date/time fields are BCD so they read naturally in a hex dump.
package version_pkg;

    localparam logic [7:0]  C_VERSION_MAJOR  = 8'd1;
    localparam logic [7:0]  C_VERSION_MINOR  = 8'd0;
    localparam logic [7:0]  C_VERSION_PATCH  = 8'd0;
    localparam logic [7:0]  C_VERSION_BUILD  = 8'd1;
    localparam logic [15:0] C_VERSION_YEAR   = 16'h2026;
    localparam logic [7:0]  C_VERSION_MONTH  = 8'h01;
    localparam logic [7:0]  C_VERSION_DAY    = 8'h01;
    localparam logic [7:0]  C_VERSION_HOUR   = 8'h00;
    localparam logic [7:0]  C_VERSION_MINUTE = 8'h00;
    localparam logic [7:0]  C_VERSION_SECOND = 8'h00;

endpackage

// File: rtl/version_readout_pkg.sv
// Frame layout, FSM state type and the byte lookup shared by the
// build-info readout controller.
package version_readout_pkg;

    localparam int         C_FRAME_LEN = 14;
    localparam logic [7:0] C_SYNC_BYTE = 8'hA5;

    localparam logic [3:0] IDX_SYNC    = 4'd0;
    localparam logic [3:0] IDX_REQ     = 4'd1;
    localparam logic [3:0] IDX_MAJOR   = 4'd2;
    localparam logic [3:0] IDX_MINOR   = 4'd3;
    localparam logic [3:0] IDX_PATCH   = 4'd4;
    localparam logic [3:0] IDX_BUILD   = 4'd5;
    localparam logic [3:0] IDX_YEAR_HI = 4'd6;
    localparam logic [3:0] IDX_YEAR_LO = 4'd7;
    localparam logic [3:0] IDX_MONTH   = 4'd8;
    localparam logic [3:0] IDX_DAY     = 4'd9;
    localparam logic [3:0] IDX_HOUR    = 4'd10;
    localparam logic [3:0] IDX_MINUTE  = 4'd11;
    localparam logic [3:0] IDX_SECOND  = 4'd12;
    localparam logic [3:0] IDX_CSUM    = 4'd13;

    typedef enum logic {IDLE, SEND} state_e;

    typedef struct packed {
        logic [7:0]  major;
        logic [7:0]  minor;
        logic [7:0]  patch;
        logic [7:0]  build;
        logic [15:0] year;
        logic [7:0]  month;
        logic [7:0]  day;
        logic [7:0]  hour;
        logic [7:0]  minute;
        logic [7:0]  second;
    } build_info_t;

    function automatic logic [7:0] payload_byte(build_info_t info, logic [2:0] req_idx,
                                                logic [3:0] idx);
        logic [7:0] b;
        case (idx)
            IDX_SYNC:    b = C_SYNC_BYTE;
            IDX_REQ:     b = {5'd0, req_idx};
            IDX_MAJOR:   b = info.major;
            IDX_MINOR:   b = info.minor;
            IDX_PATCH:   b = info.patch;
            IDX_BUILD:   b = info.build;
            IDX_YEAR_HI: b = info.year[15:8];
            IDX_YEAR_LO: b = info.year[7:0];
            IDX_MONTH:   b = info.month;
            IDX_DAY:     b = info.day;
            IDX_HOUR:    b = info.hour;
            IDX_MINUTE:  b = info.minute;
            IDX_SECOND:  b = info.second;
            default:     b = 8'h00;
        endcase
        return b;
    endfunction

    // Checksum is folded from constants and the requester index, so it
    // collapses to a small mux per requester rather than a running register.
    function automatic logic [7:0] frame_byte(build_info_t info, logic [2:0] req_idx,
                                              logic [3:0] idx);
        logic [7:0] b;
        if (idx == IDX_CSUM) begin
            b = 8'h00;
            for (int k = 0; k < C_FRAME_LEN - 1; k++) begin
                b = b ^ payload_byte(info, req_idx, 4'(k));
            end
        end else begin
            b = payload_byte(info, req_idx, idx);
        end
        return b;
    endfunction

endpackage

// File: rtl/version_readout_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first set request at or
// after the pointer, wrapping. Shared by other port-sharing controllers.
module rr_arbiter #(
    parameter  int NUM_REQ = 2,
    localparam int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   pointer,
    output logic [NUM_REQ-1:0] grant
);

    always_comb begin
        int   slot;
        logic found;
        // NOTE: every variable gets a default before any branch, so no path
        // leaves it unassigned and no latch is inferred.
        grant = '0;
        found = 1'b0;
        slot  = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            slot = (int'(pointer) + i) % NUM_REQ;
            if (!found && req[slot]) begin
                grant[slot] = 1'b1;
                found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/version_readout_ctrl.sv
// Serves one atomic 14-byte build-info frame per arbitration win onto a
// shared valid/ready/last byte stream.
module version_readout_ctrl
    import version_readout_pkg::*;
#(
    parameter int          NUM_REQ  = 2,
    parameter logic [7:0]  P_MAJOR  = version_pkg::C_VERSION_MAJOR,
    parameter logic [7:0]  P_MINOR  = version_pkg::C_VERSION_MINOR,
    parameter logic [7:0]  P_PATCH  = version_pkg::C_VERSION_PATCH,
    parameter logic [7:0]  P_BUILD  = version_pkg::C_VERSION_BUILD,
    parameter logic [15:0] P_YEAR   = version_pkg::C_VERSION_YEAR,
    parameter logic [7:0]  P_MONTH  = version_pkg::C_VERSION_MONTH,
    parameter logic [7:0]  P_DAY    = version_pkg::C_VERSION_DAY,
    parameter logic [7:0]  P_HOUR   = version_pkg::C_VERSION_HOUR,
    parameter logic [7:0]  P_MINUTE = version_pkg::C_VERSION_MINUTE,
    parameter logic [7:0]  P_SECOND = version_pkg::C_VERSION_SECOND
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [NUM_REQ-1:0] done_o,
    output logic [7:0]         m_tdata,
    output logic               m_tvalid,
    input  logic               m_tready,
    output logic               m_tlast,
    output logic               busy_o
);

    localparam int         PTR_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [2:0] GIDX_LAST = 3'(NUM_REQ - 1);
    localparam build_info_t C_INFO = '{
        major: P_MAJOR, minor: P_MINOR, patch: P_PATCH, build: P_BUILD,
        year: P_YEAR, month: P_MONTH, day: P_DAY, hour: P_HOUR,
        minute: P_MINUTE, second: P_SECOND
    };

    state_e             state_q,  state_d;
    logic [3:0]         idx_q,    idx_d;
    logic [PTR_W-1:0]   ptr_q,    ptr_d;
    logic [2:0]         gidx_q,   gidx_d;
    logic [NUM_REQ-1:0] grant_q,  grant_d;
    logic [NUM_REQ-1:0] done_q,   done_d;
    logic [7:0]         tdata_q,  tdata_d;
    logic               tvalid_q, tvalid_d;
    logic               tlast_q,  tlast_d;

    logic [NUM_REQ-1:0] arb_grant;
    logic [2:0]         arb_idx;
    logic [3:0]         idx_inc;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req     (req_i),
        .pointer (ptr_q),
        .grant   (arb_grant)
    );

    always_comb begin
        arb_idx = 3'd0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_grant[i]) arb_idx = 3'(i);
        end
    end

    assign idx_inc = idx_q + 4'd1;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        ptr_d    = ptr_q;
        gidx_d   = gidx_q;
        grant_d  = grant_q;
        done_d   = '0;
        tdata_d  = tdata_q;
        tvalid_d = tvalid_q;
        tlast_d  = tlast_q;
        case (state_q)
            IDLE: begin
                if (|req_i) begin
                    state_d  = SEND;
                    idx_d    = IDX_SYNC;
                    gidx_d   = arb_idx;
                    grant_d  = arb_grant;
                    tvalid_d = 1'b1;
                    tdata_d  = frame_byte(C_INFO, arb_idx, IDX_SYNC);
                    tlast_d  = 1'b0;
                end
            end
            SEND: begin
                // Output regs only advance on a handshake, which keeps the
                // beat stable under backpressure.
                if (m_tready) begin
                    if (idx_q == IDX_CSUM) begin
                        state_d  = IDLE;
                        idx_d    = IDX_SYNC;
                        grant_d  = '0;
                        done_d   = grant_q;
                        ptr_d    = (gidx_q == GIDX_LAST) ? '0 : PTR_W'(gidx_q + 3'd1);
                        tvalid_d = 1'b0;
                        tdata_d  = 8'h00;
                        tlast_d  = 1'b0;
                    end else begin
                        idx_d   = idx_inc;
                        tdata_d = frame_byte(C_INFO, gidx_q, idx_inc);
                        tlast_d = (idx_inc == IDX_CSUM);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops
    // sample their _d values from the same pre-edge snapshot.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            ptr_q    <= '0;
            gidx_q   <= '0;
            grant_q  <= '0;
            done_q   <= '0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            ptr_q    <= ptr_d;
            gidx_q   <= gidx_d;
            grant_q  <= grant_d;
            done_q   <= done_d;
            tdata_q  <= tdata_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
        end
    end

    assign grant_o  = grant_q;
    assign done_o   = done_q;
    assign m_tdata  = tdata_q;
    assign m_tvalid = tvalid_q;
    assign m_tlast  = tlast_q;
    assign busy_o   = (state_q == SEND);

endmodule

// File: tb/tb_version_readout_ctrl.sv
// Randomized and directed bench for version_readout_ctrl against a
// frame-level reference model (owner, byte position, round-robin pointer).
module tb_version_readout_ctrl;

    localparam int          NUM_REQ = 2;
    localparam logic [7:0]  MAJOR   = 8'd0;
    localparam logic [7:0]  MINOR   = 8'd0;
    localparam logic [7:0]  PATCH   = 8'd0;
    localparam logic [7:0]  BUILD   = 8'd76;
    localparam logic [15:0] YEAR    = 16'h2026;
    localparam logic [7:0]  MONTH   = 8'h01;
    localparam logic [7:0]  DAY     = 8'h14;
    localparam logic [7:0]  HOUR    = 8'h11;
    localparam logic [7:0]  MINUTE  = 8'h20;
    localparam logic [7:0]  SECOND  = 8'h43;

    logic               clk = 1'b0;
    logic               rst;
    logic [NUM_REQ-1:0] req_i;
    logic [NUM_REQ-1:0] grant_o;
    logic [NUM_REQ-1:0] done_o;
    logic [7:0]         m_tdata;
    logic               m_tvalid;
    logic               m_tready;
    logic               m_tlast;
    logic               busy_o;

    int n_checks = 0;
    int n_pass   = 0;
    int done_seen = 0;

    logic [7:0] exp_frame [NUM_REQ][14];

    bit                 m_busy;
    int                 m_owner;
    int                 m_pos;
    int                 m_ptr;
    logic [NUM_REQ-1:0] m_done;

    version_readout_ctrl #(
        .NUM_REQ (NUM_REQ), .P_MAJOR(MAJOR), .P_MINOR(MINOR), .P_PATCH(PATCH),
        .P_BUILD (BUILD), .P_YEAR(YEAR), .P_MONTH(MONTH), .P_DAY(DAY),
        .P_HOUR  (HOUR), .P_MINUTE(MINUTE), .P_SECOND(SECOND)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_i    (req_i),
        .grant_o  (grant_o),
        .done_o   (done_o),
        .m_tdata  (m_tdata),
        .m_tvalid (m_tvalid),
        .m_tready (m_tready),
        .m_tlast  (m_tlast),
        .busy_o   (busy_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    endtask

    function automatic int pick(input logic [NUM_REQ-1:0] req, input int ptr);
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req[(ptr + i) % NUM_REQ]) return (ptr + i) % NUM_REQ;
        end
        return -1;
    endfunction

    task automatic model_step(input logic [NUM_REQ-1:0] req, input logic rdy, input logic r);
        m_done = '0;
        if (r) begin
            m_busy = 0; m_owner = 0; m_pos = 0; m_ptr = 0;
        end else if (!m_busy) begin
            if (req != '0) begin
                m_owner = pick(req, m_ptr);
                m_busy  = 1;
                m_pos   = 0;
            end
        end else if (rdy) begin
            if (m_pos == 13) begin
                m_busy = 0;
                m_done = NUM_REQ'(1) << m_owner;
                m_ptr  = (m_owner + 1) % NUM_REQ;
            end else begin
                m_pos++;
            end
        end
    endtask

    task automatic compare_all();
        logic [NUM_REQ-1:0] g_exp;
        g_exp = m_busy ? (NUM_REQ'(1) << m_owner) : '0;
        check("grant", 32'(grant_o), 32'(g_exp));
        check("done", 32'(done_o), 32'(m_done));
        check("tvalid", 32'(m_tvalid), 32'(m_busy));
        check("busy", 32'(busy_o), 32'(m_busy));
        check("tdata", 32'(m_tdata), m_busy ? 32'(exp_frame[m_owner][m_pos]) : 32'd0);
        check("tlast", 32'(m_tlast), 32'(m_busy && m_pos == 13));
        check("grant_onehot0", 32'($onehot0(grant_o)), 32'd1);
        if (done_o != '0) done_seen++;
    endtask

    task automatic cycle(input logic [NUM_REQ-1:0] req, input logic rdy, input logic r);
        req_i = req; m_tready = rdy; rst = r;
        @(posedge clk);
        model_step(req, rdy, r);
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        logic [7:0] base [13];
        logic [7:0] x;
        base = '{8'hA5, 8'h00, MAJOR, MINOR, PATCH, BUILD, YEAR[15:8], YEAR[7:0],
                 MONTH, DAY, HOUR, MINUTE, SECOND};
        for (int r = 0; r < NUM_REQ; r++) begin
            x = 8'h00;
            for (int k = 0; k < 13; k++) begin
                exp_frame[r][k] = (k == 1) ? 8'(r) : base[k];
                x = x ^ exp_frame[r][k];
            end
            exp_frame[r][13] = x;
        end

        m_busy = 0; m_owner = 0; m_pos = 0; m_ptr = 0; m_done = '0;
        req_i = '0; m_tready = 1'b0; rst = 1'b1;

        // Reset state
        cycle('0, 1'b0, 1'b1);
        cycle('0, 1'b1, 1'b1);
        check("reset_tdata", 32'(m_tdata), 32'd0);

        // Single request, no backpressure
        done_seen = 0;
        cycle(2'b01, 1'b1, 1'b0);
        check("single_byte0", 32'(m_tdata), 32'hA5);
        for (int i = 0; i < 16; i++) cycle('0, 1'b1, 1'b0);
        check("single_done_cnt", 32'(done_seen), 32'd1);

        // Backpressure with a 5-cycle stall at idx 6
        cycle(2'b01, 1'b1, 1'b0);
        begin
            int budget;
            bit stalled;
            budget = 0; stalled = 0;
            while (m_busy && budget < 300) begin
                if (m_pos == 6 && !stalled) begin
                    stalled = 1;
                    for (int s = 0; s < 5; s++) begin
                        cycle('0, 1'b0, 1'b0);
                        check("stall_byte6", 32'(m_tdata), 32'(exp_frame[0][6]));
                    end
                end
                cycle('0, 1'($urandom_range(0, 1)), 1'b0);
                budget++;
            end
            check("bp_frame_finished", 32'(busy_o), 32'd0);
        end
        cycle('0, 1'b1, 1'b0);

        // Contention: both held, expect alternating owners
        cycle('0, 1'b1, 1'b1);
        for (int i = 0; i < 50; i++) cycle(2'b11, 1'b1, 1'b0);

        // Withdrawal: requester 1 pulses for a single cycle
        cycle('0, 1'b1, 1'b1);
        cycle(2'b10, 1'b1, 1'b0);
        check("withdraw_byte1_owner", 32'(grant_o), 32'h2);
        for (int i = 0; i < 25; i++) cycle('0, 1'b1, 1'b0);
        check("withdraw_idle", 32'(busy_o), 32'd0);

        // Reset mid-frame at idx 7, then requester 0 wins first
        cycle(2'b10, 1'b1, 1'b0);
        begin
            int budget;
            budget = 0;
            while (!(m_busy && m_pos == 7) && budget < 40) begin
                cycle(2'b11, 1'b1, 1'b0);
                budget++;
            end
            check("reach_idx7_byte", 32'(m_tdata), 32'(exp_frame[1][7]));
        end
        cycle(2'b11, 1'b1, 1'b1);
        check("midreset_valid", 32'(m_tvalid), 32'd0);
        cycle(2'b11, 1'b1, 1'b0);
        check("after_reset_grant", 32'(grant_o), 32'h1);
        for (int i = 0; i < 20; i++) cycle(2'b11, 1'b1, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cycle(NUM_REQ'($urandom_range(0, 3)),
                  ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 299) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/version_readout_ctrl.md
Name: version_readout_ctrl

Overview:
Shares one byte-stream output among NUM_REQ requesters, e.g. the UART command handler and the debug bridge. Each granted requester receives one atomic 14-byte build-info frame built from the version_pkg constants. A round-robin arbiter and a frame-sequencing FSM drive a valid/ready/last byte stream toward the shared transport mux.

Parameters:
NUM_REQ, 2, number of requesters (1..8)
P_MAJOR/P_MINOR/P_PATCH/P_BUILD, version_pkg C_VERSION_MAJOR/MINOR/PATCH/BUILD, 8-bit version fields
P_YEAR, version_pkg C_VERSION_YEAR, 16-bit BCD year
P_MONTH/P_DAY/P_HOUR/P_MINUTE/P_SECOND, version_pkg C_VERSION_*, 8-bit BCD date/time fields

Ports:
clk  in  1  single clock for all logic
rst  in  1  synchronous, active-high reset
req_i  in  NUM_REQ  level request per requester
grant_o  out  NUM_REQ  one-hot, held for the whole frame of the granted requester
done_o  out  NUM_REQ  one-cycle pulse to the requester whose frame completed
m_tdata  out  8  frame byte
m_tvalid  out  1  byte valid
m_tready  in  1  downstream accepts byte
m_tlast  out  1  high on byte 13
busy_o  out  1  high while in SEND

Behaviour:
- Reset values:
  - grant_o=0, done_o=0, m_tvalid=0, m_tlast=0, m_tdata=0, busy_o=0.
  - FSM=IDLE, byte index=0, round-robin pointer=0.
- Reset mid-frame:
  - Abort immediately; next cycle shows the reset values.
  - No done_o pulse is issued.
- FSM states:
  - IDLE: if any req_i bit is set, pick the first set bit at or after the pointer, wrapping. Register grant, idx=0, go to SEND.
  - SEND: m_tvalid=1. On m_tvalid&m_tready, idx increments. On the handshake at idx=13, go to IDLE.
  - IDLE entry after a frame: pulse done_o[g], clear grant_o, set pointer=(g+1) mod NUM_REQ.
- Latency:
  - req_i seen in IDLE at cycle N gives grant_o and m_tvalid with byte 0 at N+1.
  - With m_tready held high, bytes occupy N+1..N+14.
  - done_o pulses at N+15. Arbitration also runs at N+15, so the earliest next frame starts at N+16.
- Frame layout, idx: content
  - 0: 0xA5
  - 1: granted index
  - 2..5: MAJOR, MINOR, PATCH, BUILD
  - 6: YEAR[15:8]
  - 7: YEAR[7:0]
  - 8..12: MONTH, DAY, HOUR, MINUTE, SECOND
  - 13: XOR of bytes 0..12
- Checksum: computed combinationally from constants and the granted index. No runtime accumulator.
- Stream rules:
  - m_tdata, m_tlast and m_tvalid stay stable while m_tvalid&!m_tready.
  - m_tvalid never drops mid-frame.
  - m_tlast is asserted only at idx=13.
- Atomicity: req_i deassertion during SEND is ignored; the frame completes and done_o still pulses.
- Simultaneous requests: round-robin only; no requester is starved. A requester holding req_i gets a frame on every arbitration win.
- Widths: the index counter is 4-bit and never exceeds 13. The pointer is $clog2(NUM_REQ) bits, minimum 1; NUM_REQ=1 always grants bit 0.

Decomposition:
- Package version_readout_pkg:
  - C_FRAME_LEN=14, C_SYNC_BYTE=8'hA5.
  - Byte-index localparams (IDX_SYNC..IDX_CSUM).
  - State enum {IDLE, SEND}.
- Sub-module rr_arbiter:
  - Parameter NUM_REQ.
  - Inputs: req, pointer.
  - Output: one-hot grant. Purely combinational.
  - Reused by other shared-port controllers.

Test Plan:
- Parameters set explicitly: MAJOR=0, MINOR=0, PATCH=0, BUILD=76, YEAR=16'h2026, MONTH=01, DAY=14, HOUR=11, MINUTE=20, SECOND=43.
- Single request: req_i=01, m_tready=1 -> bytes A5 00 00 00 00 4C 20 26 01 14 11 20 43 88 on cycles N+1..N+14; tlast only on 88; done_o=01 at N+15.
- Backpressure: same request, m_tready toggled randomly and held low for 5 cycles at idx=6 -> data/last stable while stalled; identical 14-byte sequence; no drop of m_tvalid.
- Contention: req_i=11 held after reset -> frames alternate requester 0, 1, 0 with byte1=00/01/00 and checksum 88/89/88; grant_o one-hot each time; new frame starts 1 cycle after each done_o.
- Withdrawal: req_i=10 pulsed for 1 cycle -> full frame to requester 1 (byte1=01, csum 89); done_o=10; FSM returns to IDLE and stays there.
- Reset mid-frame: rst asserted at idx=7 -> next cycle all outputs 0, no done_o; req_i=11 after release -> requester 0 granted first.
